dm_sb_resp: RTL and testbench

DM_SB_RESP -- requirements
Module: dm_sb_resp

---
 rtl/dm_sb_resp_pkg.sv | 9 +
 rtl/dm_sb_resp_mem.sv | 34 +++
 rtl/dm_sb_resp.sv | 130 +++++++++++++
 tb/tb_dm_sb_resp.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_sb_resp_pkg.sv
// Shared helpers for the system-bus response model: sizing of counters and index fields.
package dm_sb_resp_pkg;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dm_sb_resp_mem.sv
// Byte-enabled word storage, asynchronously cleared, with combinational read.
module dm_sb_resp_mem import dm_sb_resp_pkg::*; #(
  parameter int unsigned BusWidth = 32,
  parameter int unsigned Depth    = 16,
  parameter int unsigned IdxW     = width_for(Depth - 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we,
  input  logic [IdxW-1:0]       idx,
  input  logic [BusWidth-1:0]   wdata,
  input  logic [BusWidth/8-1:0] be,
  output logic [BusWidth-1:0]   rdata
);

  logic [BusWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned b = 0; b < BusWidth / 8; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/dm_sb_resp.sv
// Single-outstanding bus slave with configurable grant and response latency over
// a byte-enabled word store; out-of-range accesses answer with an error.
module dm_sb_resp import dm_sb_resp_pkg::*; #(
  parameter int unsigned BusWidth  = 32,
  parameter int unsigned Depth     = 16,
  parameter int unsigned GntDelay  = 0,
  parameter int unsigned RespDelay = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slave_req_i,
  input  logic [BusWidth-1:0]   slave_add_i,
  input  logic                  slave_we_i,
  input  logic [BusWidth-1:0]   slave_wdata_i,
  input  logic [BusWidth/8-1:0] slave_be_i,
  output logic                  slave_gnt_o,
  output logic                  slave_r_valid_o,
  output logic [BusWidth-1:0]   slave_r_rdata_o,
  output logic                  slave_r_err_o,
  output logic                  busy_o
);

  localparam int unsigned BeW     = BusWidth / 8;
  localparam int unsigned AddrLsb = $clog2(BeW);
  localparam int unsigned IdxW    = width_for(Depth - 1);
  localparam int unsigned CntW    = width_for((GntDelay > RespDelay) ? GntDelay : RespDelay);
  localparam logic [CntW-1:0] GntLoad  = CntW'((GntDelay > 0) ? GntDelay - 1 : 0);
  localparam logic [CntW-1:0] RespLoad = CntW'((RespDelay > 0) ? RespDelay - 1 : 0);
  localparam logic [BusWidth:0] AddrLimit = (BusWidth + 1)'(Depth * BeW);

  typedef enum logic [1:0] {Idle, Stall, Resp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     gnt_cnt_q, gnt_cnt_d;
  logic [CntW-1:0]     resp_cnt_q, resp_cnt_d;
  logic                gnt, r_valid, in_range, mem_we;
  logic [IdxW-1:0]     idx;
  logic [BusWidth-1:0] mem_rdata, rdata_q;
  logic                err_q;

  // Compare with one spare bit so the limit itself is representable.
  assign in_range = {1'b0, slave_add_i} < AddrLimit;
  assign idx      = slave_add_i[AddrLsb +: IdxW];
  assign mem_we   = gnt & slave_we_i & in_range;

  always_comb begin
    state_d    = state_q;
    gnt_cnt_d  = gnt_cnt_q;
    resp_cnt_d = resp_cnt_q;
    gnt        = 1'b0;
    r_valid    = 1'b0;
    unique case (state_q)
      Idle: begin
        if (slave_req_i) begin
          if (GntDelay == 0) begin
            gnt        = 1'b1;
            resp_cnt_d = RespLoad;
            state_d    = Resp;
          end else begin
            gnt_cnt_d = GntLoad;
            state_d   = Stall;
          end
        end
      end
      Stall: begin
        if (!slave_req_i) begin
          state_d = Idle;
        end else if (gnt_cnt_q == '0) begin
          gnt        = 1'b1;
          resp_cnt_d = RespLoad;
          state_d    = Resp;
        end else begin
          gnt_cnt_d = gnt_cnt_q - 1'b1;
        end
      end
      Resp: begin
        if (resp_cnt_q == '0) begin
          r_valid = 1'b1;
          state_d = Idle;
        end else begin
          resp_cnt_d = resp_cnt_q - 1'b1;
        end
      end
      default: state_d = Idle;
    endcase
    // The Idle grant path is combinational from req, so it must be masked in reset.
    if (rst_i) begin
      gnt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= Idle;
      gnt_cnt_q  <= '0;
      resp_cnt_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_cnt_q  <= gnt_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      if (gnt) begin
        err_q   <= ~in_range;
        rdata_q <= (!slave_we_i && in_range) ? mem_rdata : '0;
      end
    end
  end

  dm_sb_resp_mem #(
    .BusWidth (BusWidth),
    .Depth    (Depth),
    .IdxW     (IdxW)
  ) u_mem (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (mem_we),
    .idx   (idx),
    .wdata (slave_wdata_i),
    .be    (slave_be_i),
    .rdata (mem_rdata)
  );

  assign slave_gnt_o     = gnt;
  assign slave_r_valid_o = r_valid;
  assign slave_r_rdata_o = r_valid ? rdata_q : '0;
  assign slave_r_err_o   = r_valid & err_q;
  assign busy_o          = (state_q != Idle);

endmodule

// File: tb/tb_dm_sb_resp.sv
// Directed bench for dm_sb_resp: a zero-wait instance (A) and a 3/2-latency instance (B).
module tb_dm_sb_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_add = '0, a_wdata = '0;
  logic [3:0]  a_be = '0;
  logic        a_gnt, a_rv, a_err, a_busy;
  logic [31:0] a_rdata;

  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_add = '0, b_wdata = '0;
  logic [3:0]  b_be = '0;
  logic        b_gnt, b_rv, b_err, b_busy;
  logic [31:0] b_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dm_sb_resp #(.BusWidth(32), .Depth(16), .GntDelay(0), .RespDelay(1)) u_a (
    .clk_i(clk), .rst_i(rst), .slave_req_i(a_req), .slave_add_i(a_add),
    .slave_we_i(a_we), .slave_wdata_i(a_wdata), .slave_be_i(a_be),
    .slave_gnt_o(a_gnt), .slave_r_valid_o(a_rv), .slave_r_rdata_o(a_rdata),
    .slave_r_err_o(a_err), .busy_o(a_busy)
  );

  dm_sb_resp #(.BusWidth(32), .Depth(16), .GntDelay(3), .RespDelay(2)) u_b (
    .clk_i(clk), .rst_i(rst), .slave_req_i(b_req), .slave_add_i(b_add),
    .slave_we_i(b_we), .slave_wdata_i(b_wdata), .slave_be_i(b_be),
    .slave_gnt_o(b_gnt), .slave_r_valid_o(b_rv), .slave_r_rdata_o(b_rdata),
    .slave_r_err_o(b_err), .busy_o(b_busy)
  );

  // Runs one transaction; glat = cycles from req to gnt, rlat = cycles from gnt to r_valid (-1 = timeout).
  task automatic txn(input bit on_b, input logic we, input logic [31:0] add, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic er,
                     output int glat, output int rlat);
    if (on_b) begin b_req = 1'b1; b_we = we; b_add = add; b_wdata = wd; b_be = be; end
    else      begin a_req = 1'b1; a_we = we; a_add = add; a_wdata = wd; a_be = be; end
    glat = -1; rlat = -1; rd = 'x; er = 1'bx;
    for (int k = 0; k < 50 && glat < 0; k++) begin
      @(negedge clk);
      if (on_b ? b_gnt : a_gnt) glat = k;
      @(posedge clk); #1;
    end
    if (on_b) b_req = 1'b0; else a_req = 1'b0;
    for (int k = 1; k < 50 && rlat < 0 && glat >= 0; k++) begin
      @(negedge clk);
      if (on_b ? b_rv : a_rv) begin
        rlat = k;
        rd   = on_b ? b_rdata : a_rdata;
        er   = on_b ? b_err : a_err;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; a_req = 1'b1; a_we = 1'b0; a_add = 32'h8;
    @(negedge clk);
    n_checks++; if (a_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", a_gnt); end
    n_checks++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", a_rv); end
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", a_err); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b want 0", a_busy); end
    n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b want 0", b_busy); end
    a_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int gl, rl;
    txn(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rd, er, gl, rl);
    n_checks++; if (gl !== 0) begin n_fail++; $display("FAIL wr_gnt_lat: got %0d want 0", gl); end
    n_checks++; if (rl !== 1) begin n_fail++; $display("FAIL wr_resp_lat: got %0d want 1", rl); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", er); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", rd); end
    txn(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, gl, rl);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", er); end
    n_checks++; if (rl !== 1) begin n_fail++; $display("FAIL rd_resp_lat: got %0d want 1", rl); end
  endtask

  task automatic test_partial_write();
    logic [31:0] rd; logic er; int gl, rl;
    txn(0, 1'b1, 32'hC, 32'h11223344, 4'hF, rd, er, gl, rl);
    txn(0, 1'b1, 32'hC, 32'h0000AA00, 4'h2, rd, er, gl, rl);
    txn(0, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, gl, rl);
    n_checks++; if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL partial_data: got %h want 1122aa44", rd); end
    txn(0, 1'b1, 32'hC, 32'hFFFFFFFF, 4'h0, rd, er, gl, rl);
    n_checks++; if (rl !== 1) begin n_fail++; $display("FAIL be0_resp_lat: got %0d want 1", rl); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL be0_err: got %b want 0", er); end
    txn(0, 1'b0, 32'hC, 32'h0, 4'hF, rd, er, gl, rl);
    n_checks++; if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL be0_data: got %h want 1122aa44", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int gl, rl;
    txn(0, 1'b0, 32'h40, 32'h0, 4'hF, rd, er, gl, rl);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err: got %b want 1", er); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h want 0", rd); end
    n_checks++; if (rl !== 1) begin n_fail++; $display("FAIL oor_rd_lat: got %0d want 1", rl); end
    txn(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, rd, er, gl, rl);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b want 1", er); end
    txn(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, gl, rl);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_alias_word0: got %h want 0", rd); end
    txn(0, 1'b0, 32'h3C, 32'h0, 4'hF, rd, er, gl, rl);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL last_word_err: got %b want 0", er); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL last_word_data: got %h want 0", rd); end
    txn(0, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, gl, rl);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL oor_word2_kept: got %h want deadbeef", rd); end
  endtask

  task automatic test_delays();
    logic [31:0] rd; logic er; int gl, rl, seen;
    txn(1, 1'b1, 32'h4, 32'h12345678, 4'hF, rd, er, gl, rl);
    n_checks++; if (gl !== 3) begin n_fail++; $display("FAIL dly_wr_gnt_lat: got %0d want 3", gl); end
    n_checks++; if (rl !== 2) begin n_fail++; $display("FAIL dly_wr_resp_lat: got %0d want 2", rl); end
    txn(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, gl, rl);
    n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL dly_rd_data: got %h want 12345678", rd); end
    n_checks++; if (gl !== 3 || rl !== 2) begin n_fail++; $display("FAIL dly_rd_lat: got %0d/%0d want 3/2", gl, rl); end
    // Abort: req held for one cycle only.
    b_req = 1'b1; b_we = 1'b0; b_add = 32'h4;
    seen = 0;
    @(negedge clk);
    if (b_gnt || b_rv) seen++;
    @(posedge clk); #1;
    b_req = 1'b0;
    @(negedge clk);
    n_checks++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_stall: got %b want 1", b_busy); end
    for (int i = 0; i < 8; i++) begin
      if (b_gnt || b_rv) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_gnt_rv: got %0d want 0", seen); end
    n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_idle: got %b want 0", b_busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int g1 = -1, g2 = -1, r1 = -1, r2 = -1, both = 0;
    logic [31:0] d2 = '0;
    a_req = 1'b1; a_we = 1'b0; a_add = 32'h8;
    for (int k = 0; k < 20 && r2 < 0; k++) begin
      @(negedge clk);
      if (a_gnt && a_rv) both++;
      if (a_gnt) begin if (g1 < 0) g1 = k; else if (g2 < 0) g2 = k; end
      if (a_rv) begin
        if (r1 < 0) r1 = k;
        else if (r2 < 0) begin r2 = k; d2 = a_rdata; end
      end
      @(posedge clk); #1;
      if (g2 >= 0) a_req = 1'b0;
    end
    a_req = 1'b0;
    n_checks++; if (g1 !== 0 || r1 !== 1) begin n_fail++; $display("FAIL b2b_first: got gnt %0d rv %0d want 0 1", g1, r1); end
    n_checks++; if (g2 !== 2) begin n_fail++; $display("FAIL b2b_second_gnt: got %0d want 2", g2); end
    n_checks++; if (r2 !== 3) begin n_fail++; $display("FAIL b2b_second_rv: got %0d want 3", r2); end
    n_checks++; if (both !== 0) begin n_fail++; $display("FAIL b2b_gnt_with_rv: got %0d want 0", both); end
    n_checks++; if (d2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_data: got %h want deadbeef", d2); end
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] rd; logic er; int gl, rl, seen;
    b_req = 1'b1; b_we = 1'b0; b_add = 32'h4;
    gl = -1;
    for (int k = 0; k < 10 && gl < 0; k++) begin
      @(negedge clk);
      if (b_gnt) gl = k;
      @(posedge clk); #1;
    end
    b_req = 1'b0;
    n_checks++; if (gl !== 3) begin n_fail++; $display("FAIL rir_gnt_lat: got %0d want 3", gl); end
    @(negedge clk);
    n_checks++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL rir_busy_resp: got %b want 1", b_busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (b_busy !== 1'b0 || b_rv !== 1'b0) begin n_fail++; $display("FAIL rir_immediate: got busy %b rv %b want 0 0", b_busy, b_rv); end
    n_checks++; if (b_rdata !== 32'h0 || b_err !== 1'b0) begin n_fail++; $display("FAIL rir_data_err: got %h %b want 0 0", b_rdata, b_err); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b_rv) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rir_no_rv: got %0d want 0", seen); end
    @(posedge clk); #1;
    txn(1, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, gl, rl);
    n_checks++; if (rd !== 32'h0 || rl !== 2) begin n_fail++; $display("FAIL rir_b_cleared: got %h lat %0d want 0 lat 2", rd, rl); end
    txn(0, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, gl, rl);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rir_a_word2: got %h want 0", rd); end
    txn(0, 1'b0, 32'hC, 32'h0, 4'hF, rd, er, gl, rl);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rir_a_word3: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_out_of_range();
    test_delays();
    test_back_to_back();
    test_reset_in_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
